// File: rtl/cc_demux_bus_writeback_pkg.sv
// cc_demux_bus_writeback_pkg: widths, destination count and FSM encodings
// shared by the bus write-back demux and the bus source multiplexer.
package cc_demux_bus_writeback_pkg;
  localparam int DATAWIDTH_BUS = 4;
  localparam int DATAWIDTH_DEMUX_SELECTION_REG = 5;
  localparam int DATAWIDTH_DEMUX_SELECTION_CONTROL = 6;
  localparam int NUM_DEST = 12;
  localparam int COUNT_W = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10,
    ERR   = 2'b11
  } state_e;
endpackage

// File: rtl/cc_demux_bus_writeback_onehot.sv
// cc_onehot_decoder: binary address to one-hot load vector, all-zero and
// flagged out of range when the address is not below NUM_DEST.
module cc_onehot_decoder #(
  parameter int NUM_DEST = 12,
  parameter int AW = 6
) (
  input  logic [AW-1:0]       addr,
  output logic [NUM_DEST-1:0] onehot,
  output logic                in_range
);
  always_comb begin
    in_range = addr < AW'(NUM_DEST);
    onehot = in_range ? NUM_DEST'(1) << addr : '0;
  end
endmodule

// File: rtl/cc_demux_bus_writeback.sv
// cc_demux_bus_writeback: registered write-back demux with valid/busy/done handshake.
// Build macro CC_DEMUX_WRITE_COUNT_EN adds an 8-bit completed-write counter output.
module cc_demux_bus_writeback
  import cc_demux_bus_writeback_pkg::*;
#(
  parameter int DW = DATAWIDTH_BUS,
  parameter int RW = DATAWIDTH_DEMUX_SELECTION_REG,
  parameter int CW = DATAWIDTH_DEMUX_SELECTION_CONTROL,
  parameter int ND = NUM_DEST
) (
  input  logic          CC_DEMUX_CLOCK_50,
  input  logic          CC_DEMUX_RESET_InLow,
  input  logic [DW-1:0] CC_DEMUX_data_InBUS,
  input  logic [RW-1:0] CC_DEMUX_registro_InBUS,
  input  logic [CW-1:0] CC_DEMUX_control_InBUS,
  input  logic          CC_DEMUX_selector_InBUS,
  input  logic          CC_DEMUX_valid_In,
  output logic [DW-1:0] CC_DEMUX_data_OutBUS,
  output logic [ND-1:0] CC_DEMUX_load_OutBUS,
  output logic          CC_DEMUX_busy_Out,
  output logic          CC_DEMUX_done_Out,
`ifdef CC_DEMUX_WRITE_COUNT_EN
  output logic [COUNT_W-1:0] CC_DEMUX_count_Out,
`endif
  output logic          CC_DEMUX_error_Out
);
  state_e state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [ND-1:0] load_q, load_d, onehot;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d, in_range;
  logic [CW-1:0] addr;
`ifdef CC_DEMUX_WRITE_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;
`endif
  assign addr = CC_DEMUX_selector_InBUS ? CW'(CC_DEMUX_registro_InBUS) : CC_DEMUX_control_InBUS;
  cc_onehot_decoder #(.NUM_DEST(ND), .AW(CW)) u_dec (
    .addr(addr),
    .onehot(onehot),
    .in_range(in_range)
  );
  // Outputs are computed one state ahead so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    load_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    error_d = 1'b0;
`ifdef CC_DEMUX_WRITE_COUNT_EN
    count_d = count_q;
`endif
    case (state_q)
      IDLE: if (CC_DEMUX_valid_In) begin
        busy_d = 1'b1;
        state_d = in_range ? WRITE : ERR;
        error_d = !in_range;
        load_d = onehot;
        data_d = in_range ? CC_DEMUX_data_InBUS : data_q;
      end
      WRITE: begin
        state_d = ACK;
        busy_d = 1'b1;
        done_d = 1'b1;
`ifdef CC_DEMUX_WRITE_COUNT_EN
        count_d = count_q + COUNT_W'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CC_DEMUX_CLOCK_50 or negedge CC_DEMUX_RESET_InLow) begin
    if (!CC_DEMUX_RESET_InLow) begin
      state_q <= IDLE;
      data_q <= '0;
      load_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
`ifdef CC_DEMUX_WRITE_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      load_q <= load_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
`ifdef CC_DEMUX_WRITE_COUNT_EN
      count_q <= count_d;
`endif
    end
  end
  assign CC_DEMUX_data_OutBUS = data_q;
  assign CC_DEMUX_load_OutBUS = load_q;
  assign CC_DEMUX_busy_Out = busy_q;
  assign CC_DEMUX_done_Out = done_q;
  assign CC_DEMUX_error_Out = error_q;
`ifdef CC_DEMUX_WRITE_COUNT_EN
  assign CC_DEMUX_count_Out = count_q;
`endif
endmodule

// File: tb/tb_cc_demux_bus_writeback.sv
// tb_cc_demux_bus_writeback: scenario tasks plus a scoreboard of expected
// load/data pairs popped whenever the DUT drives a load enable.
module tb_cc_demux_bus_writeback;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] data_i = '0;
  logic [4:0] reg_i = '0;
  logic [5:0] ctrl_i = '0;
  logic sel_i = 1'b0;
  logic valid_i = 1'b0;
  logic [3:0] data_o;
  logic [11:0] load_o;
  logic busy_o, done_o, err_o;
`ifdef CC_DEMUX_WRITE_COUNT_EN
  logic [7:0] count_o;
`endif
  typedef struct packed {
    logic [11:0] load;
    logic [3:0]  data;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cc_demux_bus_writeback dut (
    .CC_DEMUX_CLOCK_50(clk),
    .CC_DEMUX_RESET_InLow(rst_n),
    .CC_DEMUX_data_InBUS(data_i),
    .CC_DEMUX_registro_InBUS(reg_i),
    .CC_DEMUX_control_InBUS(ctrl_i),
    .CC_DEMUX_selector_InBUS(sel_i),
    .CC_DEMUX_valid_In(valid_i),
    .CC_DEMUX_data_OutBUS(data_o),
    .CC_DEMUX_load_OutBUS(load_o),
    .CC_DEMUX_busy_Out(busy_o),
    .CC_DEMUX_done_Out(done_o),
`ifdef CC_DEMUX_WRITE_COUNT_EN
    .CC_DEMUX_count_Out(count_o),
`endif
    .CC_DEMUX_error_Out(err_o)
  );

  always @(negedge clk) begin
    if (rst_n && load_o !== 12'h000) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: load=%b data=%h with no write pending", load_o, data_o);
      end else begin
        e = sb.pop_front();
        if (load_o !== e.load || data_o !== e.data || !$onehot(load_o)) begin
          errors++;
          $display("FAIL sb_write: load=%b data=%h expected load=%b data=%h", load_o, data_o, e.load, e.data);
        end
      end
    end
  end

  task automatic do_req(input logic s, input logic [4:0] r, input logic [5:0] c, input logic [3:0] d);
    @(negedge clk);
    sel_i = s; reg_i = r; ctrl_i = c; data_i = d; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      data_i = 4'($urandom); reg_i = 5'($urandom); ctrl_i = 6'($urandom);
      sel_i = 1'($urandom); valid_i = 1'($urandom);
      vectors++;
      if ({data_o, load_o, busy_o, done_o, err_o} !== 19'h0) begin
        errors++;
        $display("FAIL reset_hold: outs=%h expected 0", {data_o, load_o, busy_o, done_o, err_o});
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({data_o, load_o, busy_o, done_o, err_o} !== 19'h0) begin
      errors++;
      $display("FAIL reset_release: outs=%h expected 0", {data_o, load_o, busy_o, done_o, err_o});
    end
  endtask

  task automatic test_control_write;
    sb.push_back('{load: 12'h800, data: 4'hA});
    do_req(1'b0, 5'd0, 6'b001011, 4'b1010);
    vectors++;
    if (load_o !== 12'h800 || data_o !== 4'hA || busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_write: load=%b data=%h busy=%b done=%b expected 100000000000 a 1 0", load_o, data_o, busy_o, done_o);
    end
    @(negedge clk);
    vectors++;
    if (load_o !== 12'h000 || done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_ack: load=%b done=%b busy=%b expected 0 1 1", load_o, done_o, busy_o);
    end
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || data_o !== 4'hA) begin
      errors++;
      $display("FAIL ctrl_idle: busy=%b done=%b data=%h expected 0 0 a", busy_o, done_o, data_o);
    end
  endtask

  task automatic test_register_write;
    sb.push_back('{load: 12'h008, data: 4'h6});
    do_req(1'b1, 5'b00011, 6'b001011, 4'b0110);
    vectors++;
    if (load_o !== 12'h008 || data_o !== 4'h6 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reg_write: load=%b data=%h busy=%b expected 000000001000 6 1", load_o, data_o, busy_o);
    end
    @(negedge clk);
    vectors++;
    if (load_o !== 12'h000 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL reg_ack: load=%b done=%b expected 0 1", load_o, done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range;
    logic [11:0] cases [3];
    cases[0] = {1'b0, 5'd0, 6'd12};
    cases[1] = {1'b1, 5'd31, 6'd0};
    cases[2] = {1'b1, 5'd12, 6'd3};
    for (int i = 0; i < 3; i++) begin
      do_req(cases[i][11], cases[i][10:6], cases[i][5:0], 4'hF);
      vectors++;
      if (err_o !== 1'b1 || load_o !== 12'h000 || done_o !== 1'b0 || busy_o !== 1'b1 || data_o !== 4'h6) begin
        errors++;
        $display("FAIL oor_%0d: err=%b load=%b done=%b busy=%b data=%h expected 1 0 0 1 6", i, err_o, load_o, done_o, busy_o, data_o);
      end
      @(negedge clk);
      vectors++;
      if (err_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL oor_after_%0d: err=%b done=%b busy=%b expected 0 0 0", i, err_o, done_o, busy_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sel_i = 1'b0; ctrl_i = 6'd1; data_i = 4'h1; valid_i = 1'b1;
    sb.push_back('{load: 12'h002, data: 4'h1});
    @(negedge clk);
    ctrl_i = 6'd2; data_i = 4'h2;
    vectors++;
    if (load_o !== 12'h002 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: load=%b busy=%b expected 000000000010 1", load_o, busy_o);
    end
    @(negedge clk);
    ctrl_i = 6'd3; data_i = 4'h3;
    vectors++;
    if (done_o !== 1'b1 || load_o !== 12'h000) begin
      errors++;
      $display("FAIL b2b_done: done=%b load=%b expected 1 0", done_o, load_o);
    end
    @(negedge clk);
    ctrl_i = 6'd4; data_i = 4'h4;
    sb.push_back('{load: 12'h010, data: 4'h4});
    vectors++;
    if (busy_o !== 1'b0 || load_o !== 12'h000 || data_o !== 4'h1) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b load=%b data=%h expected 0 0 1", busy_o, load_o, data_o);
    end
    @(negedge clk);
    valid_i = 1'b0;
    vectors++;
    if (load_o !== 12'h010 || data_o !== 4'h4) begin
      errors++;
      $display("FAIL b2b_second: load=%b data=%h expected 000000010000 4", load_o, data_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    sb.push_back('{load: 12'h020, data: 4'h9});
    do_req(1'b0, 5'd0, 6'd5, 4'h9);
    vectors++;
    if (load_o !== 12'h020) begin
      errors++;
      $display("FAIL midrst_write: load=%b expected 000000100000", load_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (load_o !== 12'h000 || busy_o !== 1'b0 || done_o !== 1'b0 || data_o !== 4'h0) begin
      errors++;
      $display("FAIL midrst_clear: load=%b busy=%b done=%b data=%h expected 0 0 0 0", load_o, busy_o, done_o, data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done_o !== 1'b0 || load_o !== 12'h000 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after: done=%b load=%b busy=%b expected 0 0 0", done_o, load_o, busy_o);
      end
    end
`ifdef CC_DEMUX_WRITE_COUNT_EN
    vectors++;
    if (count_o !== 8'd0) begin
      errors++;
      $display("FAIL count_reset: count=%0d expected 0", count_o);
    end
    for (int i = 0; i < 257; i++) begin
      sb.push_back('{load: 12'(1) << (i % 12), data: 4'(i)});
      do_req(1'b0, 5'd0, 6'(i % 12), 4'(i));
      repeat (2) @(negedge clk);
      if (i == 255 || i == 256) begin
        vectors++;
        if (count_o !== 8'(i + 1)) begin
          errors++;
          $display("FAIL count_wrap_%0d: count=%0d expected %0d", i, count_o, 8'(i + 1));
        end
      end
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_control_write();
    test_register_write();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d writes pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
